// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch stage.
//   DEF_RESET_PC : default PC after reset (low words are kept free for the
//                  interrupt vector)
//   DEF_IRQ_VEC  : default interrupt target PC
//   entry_w()    : width of one prefetch FIFO entry, laid out as {pc, instr}
package fetch_unit_pkg;

  localparam logic [31:0] DEF_RESET_PC = 32'h0000_0020;
  localparam logic [31:0] DEF_IRQ_VEC  = 32'h0000_0000;

  function automatic int entry_w(input int aw, input int iw);
    return aw + iw;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous prefetch FIFO with a synchronous clear and an asynchronous reset.
//   clk, rst  : clock, asynchronous active-high reset
//   clear     : drop all entries (wins over push/pop in the same cycle)
//   push, din : write one entry (accepted when not full, or when full and popping)
//   pop       : remove the head entry (ignored when empty)
//   dout      : head entry, combinational from storage
//   count     : number of entries held
//   empty     : count == 0
// DEPTH must be a power of two so that the pointers wrap naturally.
module fetch_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          push,
  input  logic [W-1:0]  din,
  input  logic          pop,
  output logic [W-1:0]  dout,
  output logic [CW-1:0] count,
  output logic          empty
);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          full;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  // When full, a simultaneous pop frees the slot being written.
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  // Storage needs no reset: count/empty gate every read.
  always_ff @(posedge clk) begin
    if (do_push && !clear) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage. Owns the PC, drives a synchronous-read instruction
// memory, buffers {pc, instr} pairs in a prefetch FIFO and hands them to decode.
// Optional interrupt vectoring is compiled in when FETCH_IRQ_EN is defined.
//   clk, rst        : clock, asynchronous active-high reset
//   imem_rd         : read strobe, data returns on imem_data the next cycle
//   imem_addr       : read address, low IMEM_AW bits of the PC
//   imem_data       : read data
//   redirect_valid  : load redirect_pc and flush buffered/in-flight words
//   redirect_pc     : new PC
//   out_valid/out_ready/out_instr/out_pc : instruction stream to decode
//   irq_req         : level interrupt request          (FETCH_IRQ_EN only)
//   irq_ack         : one-cycle acknowledge            (FETCH_IRQ_EN only)
//   epc             : saved return PC, held until the next acknowledge (FETCH_IRQ_EN only)
//
// Handshake: an instruction transfers on every cycle where out_valid and
// out_ready are both high; while out_valid && !out_ready, out_instr/out_pc
// hold. A flush (redirect or interrupt) drops out_valid the following cycle.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int AW      = 32,
  parameter int IMEM_AW = 20,
  parameter int IW      = 16,
  parameter int DEPTH   = 4,
  parameter logic [AW-1:0] RESET_PC = AW'(DEF_RESET_PC)
`ifdef FETCH_IRQ_EN
  , parameter logic [AW-1:0] IRQ_VEC = AW'(DEF_IRQ_VEC)
`endif
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_rd,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [IW-1:0]      imem_data,
  input  logic               redirect_valid,
  input  logic [AW-1:0]      redirect_pc,
`ifdef FETCH_IRQ_EN
  input  logic               irq_req,
  output logic               irq_ack,
  output logic [AW-1:0]      epc,
`endif
  output logic               out_valid,
  input  logic               out_ready,
  output logic [IW-1:0]      out_instr,
  output logic [AW-1:0]      out_pc
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int EW = entry_w(AW, IW);

  logic [AW-1:0] pc;
  logic [AW-1:0] issued_pc;
  logic          inflight;
  logic          flush;
  logic [AW-1:0] flush_pc;
  logic          push;
  logic          pop;
  logic          empty;
  logic [CW-1:0] count;
  logic [CW:0]   used;
  logic [EW-1:0] head;

`ifdef FETCH_IRQ_EN
  logic          irq_take;
  logic [AW-1:0] oldest_pc;

  // irq_ack doubles as a one-cycle mask so a held level is not re-taken
  // in the cycle right after it was accepted.
  assign irq_take = irq_req && !irq_ack && !redirect_valid;
  assign flush    = redirect_valid || irq_take;
  assign flush_pc = redirect_valid ? redirect_pc : IRQ_VEC;

  // Everything buffered or in flight is a run of consecutive PCs ending just
  // before pc, so the oldest undelivered PC is pc minus what is outstanding.
  // With no pop this is the FIFO head, else the in-flight PC, else pc; a pop
  // in the same cycle means the head was delivered and the next one is oldest.
  assign oldest_pc = pc - AW'(count) - AW'(inflight) + AW'(pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      irq_ack <= 1'b0;
      epc     <= '0;
    end else begin
      irq_ack <= irq_take;
      if (irq_take) epc <= oldest_pc;
    end
  end
`else
  assign flush    = redirect_valid;
  assign flush_pc = redirect_pc;
`endif

  // Credit check: every issued read has a FIFO slot reserved for its return.
  assign used      = {1'b0, count} + (CW + 1)'(inflight);
  assign imem_rd   = !rst && !flush && (used < (CW + 1)'(DEPTH));
  assign imem_addr = pc[IMEM_AW-1:0];

  // A response arriving in a flush cycle belongs to the old path: drop it.
  assign push = inflight && !flush;
  assign pop  = out_valid && out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc        <= RESET_PC;
      inflight  <= 1'b0;
      issued_pc <= '0;
    end else if (flush) begin
      pc       <= flush_pc;
      inflight <= 1'b0;
    end else begin
      inflight <= imem_rd;
      if (imem_rd) begin
        pc        <= pc + AW'(1);
        issued_pc <= pc;
      end
    end
  end

  fetch_fifo #(
    .W     (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clear (flush),
    .push  (push),
    .din   ({issued_pc, imem_data}),
    .pop   (pop),
    .dout  (head),
    .count (count),
    .empty (empty)
  );

  assign out_valid           = !empty;
  assign {out_pc, out_instr} = head;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit (default parameters). With FETCH_IRQ_EN defined the
// interrupt ports are connected and the interrupt steps are included.
// Reference model: the delivered stream is the run of consecutive PCs starting
// at the last reset/redirect/interrupt target, each paired with the memory
// word at that address.
module tb_fetch_unit;

  localparam int AW      = 32;
  localparam int IMEM_AW = 20;
  localparam int IW      = 16;
  localparam int DEPTH   = 4;
  localparam logic [AW-1:0] RESET_PC = 32'h0000_0020;
  localparam logic [AW-1:0] IRQ_VEC  = 32'h0000_0000;

  // ---------------- clock / reset ----------------
  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               imem_rd;
  logic [IMEM_AW-1:0] imem_addr;
  logic [IW-1:0]      imem_data = '0;
  logic               redirect_valid = 1'b0;
  logic [AW-1:0]      redirect_pc = '0;
  logic               out_valid;
  logic               out_ready = 1'b0;
  logic [IW-1:0]      out_instr;
  logic [AW-1:0]      out_pc;
`ifdef FETCH_IRQ_EN
  logic               irq_req = 1'b0;
  logic               irq_ack;
  logic [AW-1:0]      epc;
  logic               ack_model = 1'b0;
  logic [AW-1:0]      epc_model = '0;
`endif

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk            (clk),
    .rst            (rst),
    .imem_rd        (imem_rd),
    .imem_addr      (imem_addr),
    .imem_data      (imem_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
`ifdef FETCH_IRQ_EN
    .irq_req        (irq_req),
    .irq_ack        (irq_ack),
    .epc            (epc),
`endif
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc)
  );

  // Instruction memory contents: a fixed scramble of the address.
  function automatic logic [IW-1:0] mem_word(input logic [IMEM_AW-1:0] a);
    logic [31:0] h;
    h = ({12'h0, a} * 32'h0001_9E37) ^ 32'h0000_5A5A;
    return h[15:0] ^ h[31:16];
  endfunction

  // Synchronous-read memory responder.
  always @(posedge clk) begin
    if (imem_rd) imem_data <= mem_word(imem_addr);
  end

  // ---------------- scoreboard ----------------
  int checks   = 0;
  int failures = 0;
  int n_issue  = 0;
  logic [AW+IW-1:0] exp_q[$];
  logic [AW-1:0]    gen_pc = RESET_PC;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_restart(input logic [AW-1:0] p);
    exp_q.delete();
    gen_pc = p;
  endtask

  task automatic exp_fill();
    if (exp_q.size() == 0) begin
      exp_q.push_back({gen_pc, mem_word(gen_pc[IMEM_AW-1:0])});
      gen_pc = gen_pc + 1;
    end
  endtask

  // Compare the current cycle against the model, then advance the model.
  task automatic score();
    logic [AW+IW-1:0] e;
`ifdef FETCH_IRQ_EN
    logic take;
    chk("irq_ack", irq_ack, ack_model);
    chk("epc", epc, epc_model);
`endif
    if (out_valid && out_ready) begin
      exp_fill();
      e = exp_q.pop_front();
      chk("deliver_pc", out_pc, e[AW+IW-1:IW]);
      chk("deliver_instr", out_instr, e[IW-1:0]);
    end
`ifdef FETCH_IRQ_EN
    take = irq_req && !ack_model && !redirect_valid && !rst;
    if (take) begin
      exp_fill();
      epc_model = exp_q[0][AW+IW-1:IW];
      model_restart(IRQ_VEC);
    end
    ack_model = take;
`endif
    if (redirect_valid) model_restart(redirect_pc);
  endtask

  // ---------------- driver ----------------
  task automatic step(input logic rdy, input logic redir, input logic [AW-1:0] rpc,
                      input logic irq = 1'b0);
    @(negedge clk);
    out_ready      = rdy;
    redirect_valid = redir;
    redirect_pc    = rpc;
`ifdef FETCH_IRQ_EN
    irq_req        = irq;
`endif
    #1;
    if (imem_rd) n_issue++;
    score();
  endtask

  // Release reset with out_ready=1 and check the opening fetch sequence.
  task automatic boot();
    @(negedge clk);
    rst            = 1'b0;
    out_ready      = 1'b1;
    redirect_valid = 1'b0;
    #1;
    chk("boot_rd", imem_rd, 1'b1);
    chk("boot_addr0", imem_addr, 20'h20);
    chk("boot_valid0", out_valid, 1'b0);
    score();
    for (int i = 1; i < 5; i++) begin
      step(1'b1, 1'b0, '0);
      chk("boot_addr", imem_addr, 64'(20'h20 + i));
      chk("boot_valid", out_valid, 64'(i >= 2));
    end
  endtask

  initial begin
    int base;
    // Reset state.
    repeat (3) @(negedge clk);
    #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_imem_rd", imem_rd, 1'b0);
`ifdef FETCH_IRQ_EN
    chk("rst_irq_ack", irq_ack, 1'b0);
    chk("rst_epc", epc, '0);
`endif
    model_restart(RESET_PC);
    boot();

    // Sustained one-per-cycle throughput.
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 1'b0, '0);
      chk("stream_valid", out_valid, 1'b1);
    end

    // Stall after a redirect: exactly DEPTH reads, then imem_rd stays low.
    step(1'b0, 1'b1, 32'h40);
    chk("redir_no_issue", imem_rd, 1'b0);
    base = n_issue;
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, '0);
    chk("stall_issues", n_issue - base, DEPTH);
    chk("stall_rd_low", imem_rd, 1'b0);
    chk("stall_head", out_pc, 32'h40);
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b0, '0);
      chk("drain_valid", out_valid, 1'b1);
    end

    // Back-pressure until credits are exhausted with a read in flight, then
    // redirect while popping.
    step(1'b0, 1'b0, '0);
    step(1'b0, 1'b0, '0);
    step(1'b1, 1'b1, 32'h100);
    step(1'b1, 1'b0, '0);
    chk("redir_valid_drop", out_valid, 1'b0);
    chk("redir_first_rd", imem_rd, 1'b1);
    chk("redir_first_addr", imem_addr, 20'h100);
    step(1'b1, 1'b0, '0);
    step(1'b1, 1'b0, '0);
    chk("redir_first_pc", out_pc, 32'h100);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, '0);

    // Back-to-back redirects: only the last target is delivered.
    step(1'b1, 1'b1, 32'h300);
    step(1'b1, 1'b1, 32'h400);
    step(1'b1, 1'b0, '0);
    chk("dbl_redir_valid", out_valid, 1'b0);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, '0);

    // PC wrap at the top of the address space.
    step(1'b1, 1'b1, 32'hFFFF_FFFF);
    step(1'b1, 1'b0, '0);
    step(1'b1, 1'b0, '0);
    step(1'b1, 1'b0, '0);
    chk("wrap_pc_hi", out_pc, 32'hFFFF_FFFF);
    step(1'b1, 1'b0, '0);
    chk("wrap_pc_lo", out_pc, 32'h0);

`ifdef FETCH_IRQ_EN
    // Interrupt with head PC 0x25.
    step(1'b0, 1'b1, 32'h25);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, '0);
    step(1'b0, 1'b0, '0, 1'b1);
    step(1'b0, 1'b0, '0);
    chk("irq_ack_pulse", irq_ack, 1'b1);
    chk("irq_epc", epc, 32'h25);
    chk("irq_flush_valid", out_valid, 1'b0);
    step(1'b1, 1'b0, '0);
    chk("irq_ack_drop", irq_ack, 1'b0);
    step(1'b1, 1'b0, '0);
    chk("irq_vec_pc", out_pc, IRQ_VEC);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, '0);
    // Redirect and interrupt together: redirect first, interrupt next cycle.
    step(1'b0, 1'b1, 32'h50, 1'b1);
    step(1'b0, 1'b0, '0, 1'b1);
    chk("irq_deferred", irq_ack, 1'b0);
    step(1'b0, 1'b0, '0);
    chk("irq_late_ack", irq_ack, 1'b1);
    chk("irq_late_epc", epc, 32'h50);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, '0);
`endif

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      logic rdy;
      logic redir;
      logic [AW-1:0] rpc;
      logic irq;
      rdy   = ($urandom_range(0, 99) < 70);
      redir = ($urandom_range(0, 99) < 4);
      rpc   = ($urandom_range(0, 1) == 1) ? $urandom() : 32'($urandom_range(0, 4095));
      irq   = ($urandom_range(0, 99) < 3);
      step(rdy, redir, rpc, irq);
    end

    // Reset mid-stream with a read in flight.
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, '0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_valid", out_valid, 1'b0);
    chk("midrst_rd", imem_rd, 1'b0);
    model_restart(RESET_PC);
`ifdef FETCH_IRQ_EN
    irq_req   = 1'b0;
    ack_model = 1'b0;
    epc_model = '0;
`endif
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 1'b0, '0);
      chk("midrst_hold", out_valid, 1'b0);
    end
    boot();
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
